// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue and register-file writeback signals for the multiply/divide unit
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic            write_reg;
  logic [4:0]      write_reg_addr;
  logic [XLEN-1:0] write_reg_data;
  modport master (
    output start, op, rs1_data, rs2_data, rd_addr,
    input  busy, done, write_reg, write_reg_addr, write_reg_data
  );
  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr,
    output busy, done, write_reg, write_reg_addr, write_reg_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL/MULHU/DIVU/REMU, one operand bit per cycle, fixed latency
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   result;
  // Both datapaths step every BUSY cycle; op only picks which result is written back.
  always_comb begin
    sum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a} : '0);
    trial  = {rem, quo[XLEN-1]};
    diff   = trial - {1'b0, b};
    ge     = trial >= {1'b0, b};
    result = op_q == 2'b00 ? prod[XLEN-1:0] :
             op_q == 2'b01 ? prod[2*XLEN-1:XLEN] :
             op_q == 2'b10 ? quo : rem;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.write_reg      <= 1'b0;
      bus.write_reg_addr <= '0;
      bus.write_reg_data <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.write_reg <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= BUSY;
          bus.busy <= 1'b1;
          cnt      <= CW'(XLEN);
          op_q     <= bus.op;
          rd_q     <= bus.rd_addr;
          a        <= bus.rs1_data;
          b        <= bus.rs2_data;
          prod     <= {{XLEN{1'b0}}, bus.rs2_data};
          quo      <= bus.rs1_data;
          rem      <= '0;
        end
        BUSY: begin
          prod  <= {sum, prod[XLEN-1:1]};
          quo   <= {quo[XLEN-2:0], ge};
          rem   <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
          cnt   <= cnt - CW'(1);
          state <= cnt == CW'(1) ? DONE : BUSY;
        end
        DONE: begin
          state              <= IDLE;
          bus.busy           <= 1'b0;
          bus.done           <= 1'b1;
          bus.write_reg      <= rd_q != 5'd0;
          bus.write_reg_addr <= rd_q;
          bus.write_reg_data <= result;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results, latency and reset-abort checks
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  muldiv_unit_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd, input logic [31:0] exp, input logic inject);
    int lat;
    logic stray;
    lat = 0;
    stray = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs1_data = x; bus.rs2_data = y; bus.rd_addr = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      if (inject && k == 5) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_addr = 5'd9;
      end
      if (inject && k == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.write_reg) stray = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_stray_wr"}, 64'(stray), 64'd0);
    check({tag, "_wr"}, 64'(bus.write_reg), 64'(rd != 5'd0));
    check({tag, "_addr"}, 64'(bus.write_reg_addr), 64'(rd));
    check({tag, "_data"}, 64'(bus.write_reg_data), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 64'({bus.done, bus.write_reg}), 64'd0);
    check({tag, "_hold"}, 64'(bus.write_reg_data), 64'(exp));
  endtask
  initial begin
    int seen;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_wr", 64'(bus.write_reg), 64'd0);
    check("rst_addr", 64'(bus.write_reg_addr), 64'd0);
    check("rst_data", 64'(bus.write_reg_data), 64'd0);
    reset = 1'b0;
    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
    do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
    do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 1'b0);
    do_op("divu100_7", 2'b10, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
    do_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);
    do_op("divu_msb", 2'b10, 32'h8000_0000, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
    do_op("divu_by0", 2'b10, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b0);
    do_op("remu_by0", 2'b11, 32'h1234, 32'd0, 5'd7, 32'h1234, 1'b0);
    do_op("mul_rd0_ign", 2'b00, 32'd3, 32'd3, 5'd0, 32'd9, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.rs1_data = 32'd7; bus.rs2_data = 32'd6; bus.rd_addr = 5'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'({bus.done, bus.write_reg}), 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.write_reg) seen++;
    end
    check("abort_no_pulse", 64'(seen), 64'd0);
    do_op("after_abort", 2'b01, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'd1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation.
REQ-005 SHALL have port: op  input  2  operation select: 00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU; all unsigned.
REQ-006 SHALL have port: rs1_data  input  XLEN  multiplicand/dividend, taken from register-file read port 1.
REQ-007 SHALL have port: rs2_data  input  XLEN  multiplier/divisor, taken from register-file read port 2.
REQ-008 SHALL have port: rd_addr  input  5  destination register index.
REQ-009 SHALL have port: busy  output  1  unit occupied; start is ignored while busy.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: write_reg  output  1  register-file write enable.
REQ-012 SHALL have port: write_reg_addr  output  5  register-file write address.
REQ-013 SHALL have port: write_reg_data  output  XLEN  register-file write data.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 SHALL accept start only in IDLE; on acceptance, latch op, rs1_data, rs2_data and rd_addr, load the iteration counter with XLEN, and enter BUSY.
REQ-016 SHALL ignore start in BUSY and DONE; latched operands, op and rd_addr SHALL NOT change until the next acceptance.
REQ-017 SHALL process one operand bit per cycle in BUSY: shift-add multiply into a 2*XLEN product; restoring divide producing quotient and remainder.
REQ-018 SHALL decrement the counter once per BUSY cycle and enter DONE when it reaches 0, after exactly XLEN BUSY cycles.
REQ-019 SHALL have fixed latency: start accepted at edge N gives done=1 during the cycle after edge N+XLEN+1 (33 cycles after acceptance for XLEN=32), independent of operand values.
REQ-020 SHALL drive in DONE, for exactly one cycle: done=1; write_reg_addr=latched rd_addr; write_reg_data=result; then return to IDLE.
REQ-021 SHALL select the result as: MUL = product[XLEN-1:0]; MULHU = product[2*XLEN-1:XLEN]; DIVU = quotient; REMU = remainder.
REQ-022 SHALL, on divide by zero, return all ones for DIVU and the unmodified dividend for REMU, with unchanged latency.
REQ-023 SHALL set write_reg=1 in DONE only when rd_addr is nonzero; rd_addr=0 gives done=1 with write_reg=0.
REQ-024 SHALL keep write_reg=0 and done=0 in every cycle outside DONE.
REQ-025 SHALL hold write_reg_data and write_reg_addr at their last DONE values outside DONE.
REQ-026 SHALL drive busy=1 in BUSY and DONE, and busy=0 in IDLE.
REQ-027 SHALL have all outputs registered, with no combinational path from inputs to outputs.
REQ-028 SHALL give the earliest next acceptance at the edge following DONE, for a throughput of one operation per XLEN+2 cycles.

Reset
REQ-029 SHALL, with reset=1 at a posedge, enter IDLE and clear: busy=0, done=0, write_reg=0, write_reg_addr=0, write_reg_data=0, counter=0.
REQ-030 SHALL give reset priority over start and over every FSM transition.
REQ-031 SHALL abort any operation on reset in BUSY or DONE, with no write_reg pulse for the aborted operation.

Verification
REQ-032 SHALL pass: MUL 7 x 6, rd=5 -> done 33 cycles after acceptance; write_reg=1, addr=5, data=42.
REQ-033 SHALL pass: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> data=0xFFFFFFFE; MUL same operands -> data=0x00000001.
REQ-034 SHALL pass: DIVU 100/7 -> data=14; REMU 100/7 -> data=2; DIVU 0x80000000/1 -> data=0x80000000.
REQ-035 SHALL pass: DIVU 5/0 -> data=0xFFFFFFFF; REMU 0x1234/0 -> data=0x1234; both at standard latency.
REQ-036 SHALL pass: MUL 3 x 3 with rd=0 -> done=1, write_reg=0; a new start during BUSY is ignored and the first result is unchanged.
REQ-037 SHALL pass: reset asserted 10 cycles into BUSY -> busy=0 after that edge, no done/write_reg; next start completes normally.
